// File: rtl/rx_comma_align_ctrl.sv
// rx_comma_align_ctrl
//   Per-channel comma-alignment controller for a 2.5G BASE-X GT receive path.
//   Hunts for comma lock with RXCOMMAALIGNEN asserted, declares alignment once
//   rxbyteisaligned has been stable for STABLE_CYCLES, and re-hunts on loss of
//   alignment or a realign strobe. Debug counters saturate and clear on reset only.
// Ports
//   clk                 rx user clock
//   resetn              asynchronous active-low reset
//   enable              1 = run, 0 = force IDLE
//   rx_resetdone        GT RX reset-done (asynchronous, synchronised here)
//   rxbyteisaligned     GT byte-aligned flag (clk domain)
//   rxbyterealign       GT realign strobe (clk domain)
//   rxcommaalignen_out  comma-align enable to GT / GPI mapper (high in HUNT)
//   aligned             high while LOCKED
//   align_lost          1-cycle pulse on LOCKED->HUNT
//   hunt_timeout        1-cycle pulse when the hunt timer expires
//   realign_cnt         saturating LOCKED->HUNT count
//   timeout_cnt         saturating hunt_timeout count
module rx_comma_align_ctrl #(
   parameter int STABLE_CYCLES = 16,
   parameter int LOSS_CYCLES   = 4,
   parameter int HUNT_TIMEOUT  = 65535,
   parameter int CNT_W         = 8
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             enable,
   input  logic             rx_resetdone,
   input  logic             rxbyteisaligned,
   input  logic             rxbyterealign,
   output logic             rxcommaalignen_out,
   output logic             aligned,
   output logic             align_lost,
   output logic             hunt_timeout,
   output logic [CNT_W-1:0] realign_cnt,
   output logic [CNT_W-1:0] timeout_cnt
);
   localparam int SW = $clog2(STABLE_CYCLES) + 1;
   localparam int LW = $clog2(LOSS_CYCLES) + 1;
   localparam int HW = $clog2(HUNT_TIMEOUT) + 1;
   localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CYCLES - 1);
   localparam logic [LW-1:0] LOSS_LAST   = LW'(LOSS_CYCLES - 1);
   localparam logic [HW-1:0] HUNT_LAST   = HW'(HUNT_TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, HUNT, LOCKED} state_t;

   state_t           state_q, state_d;
   logic [1:0]       rdone_sync;
   logic             rdone_s;
   logic [SW-1:0]    stable_q, stable_d;
   logic [LW-1:0]    loss_q, loss_d;
   logic [HW-1:0]    hunt_q, hunt_d;
   logic [CNT_W-1:0] rcnt_d, tcnt_d;
   logic             lost_d, to_d, qual;

   assign rdone_s = rdone_sync[1];
   // A realign strobe invalidates any accumulated stability.
   assign qual    = rxbyteisaligned & ~rxbyterealign;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rdone_sync         <= '0;
         state_q            <= IDLE;
         stable_q           <= '0;
         loss_q             <= '0;
         hunt_q             <= '0;
         rxcommaalignen_out <= 1'b0;
         aligned            <= 1'b0;
         align_lost         <= 1'b0;
         hunt_timeout       <= 1'b0;
         realign_cnt        <= '0;
         timeout_cnt        <= '0;
      end else begin
         rdone_sync         <= {rdone_sync[0], rx_resetdone};
         state_q            <= state_d;
         stable_q           <= stable_d;
         loss_q             <= loss_d;
         hunt_q             <= hunt_d;
         // Outputs are decoded from the next state so they are true flops.
         rxcommaalignen_out <= (state_d == HUNT);
         aligned            <= (state_d == LOCKED);
         align_lost         <= lost_d;
         hunt_timeout       <= to_d;
         realign_cnt        <= rcnt_d;
         timeout_cnt        <= tcnt_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      stable_d = stable_q;
      loss_d   = loss_q;
      hunt_d   = hunt_q;
      rcnt_d   = realign_cnt;
      tcnt_d   = timeout_cnt;
      lost_d   = 1'b0;
      to_d     = 1'b0;
      // Disable / GT-not-ready wins over everything; no pulses, counters kept.
      if (!enable || !rdone_s) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               state_d  = HUNT;
               stable_d = '0;
               hunt_d   = '0;
            end
            HUNT: begin
               if (qual && stable_q == STABLE_LAST) begin
                  // Lock beats a coincident timeout: no pulse.
                  state_d = LOCKED;
                  loss_d  = '0;
               end else begin
                  stable_d = qual ? stable_q + 1'b1 : '0;
                  if (hunt_q == HUNT_LAST) begin
                     to_d   = 1'b1;
                     hunt_d = '0;
                     if (timeout_cnt != '1) tcnt_d = timeout_cnt + 1'b1;
                  end else begin
                     hunt_d = hunt_q + 1'b1;
                  end
               end
            end
            LOCKED: begin
               if (rxbyterealign || (!rxbyteisaligned && loss_q == LOSS_LAST)) begin
                  state_d  = HUNT;
                  stable_d = '0;
                  hunt_d   = '0;
                  lost_d   = 1'b1;
                  if (realign_cnt != '1) rcnt_d = realign_cnt + 1'b1;
               end else if (!rxbyteisaligned) begin
                  loss_d = loss_q + 1'b1;
               end else begin
                  loss_d = '0;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_rx_comma_align_ctrl.sv
module tb_rx_comma_align_ctrl;
   localparam int STABLE = 16;
   localparam int LOSS   = 4;
   localparam int HT     = 8;
   localparam int CW     = 8;
   localparam int CMAX   = (1 << CW) - 1;

   logic clk = 1'b0;
   logic resetn, enable, rx_resetdone, rxbyteisaligned, rxbyterealign;
   logic rxcommaalignen_out, aligned, align_lost, hunt_timeout;
   logic [CW-1:0] realign_cnt, timeout_cnt;

   int tests = 0;
   int errors = 0;

   always #5 clk = ~clk;

   rx_comma_align_ctrl #(
      .STABLE_CYCLES(STABLE), .LOSS_CYCLES(LOSS), .HUNT_TIMEOUT(HT), .CNT_W(CW)
   ) dut (
      .clk(clk), .resetn(resetn), .enable(enable), .rx_resetdone(rx_resetdone),
      .rxbyteisaligned(rxbyteisaligned), .rxbyterealign(rxbyterealign),
      .rxcommaalignen_out(rxcommaalignen_out), .aligned(aligned),
      .align_lost(align_lost), .hunt_timeout(hunt_timeout),
      .realign_cnt(realign_cnt), .timeout_cnt(timeout_cnt)
   );

   // Reference model: mode 0 = idle, 1 = hunting, 2 = locked.
   int m_mode, run_len, hunt_age, zero_run, m_rcnt, m_tcnt;
   bit m_lost, m_to;
   bit rd_hist[2];

   logic [19:0] obs, expv;
   assign obs = {rxcommaalignen_out, aligned, align_lost, hunt_timeout, realign_cnt, timeout_cnt};
   always_comb expv = {m_mode == 1, m_mode == 2, m_lost, m_to, m_rcnt[CW-1:0], m_tcnt[CW-1:0]};

   task automatic model_reset();
      m_mode = 0; run_len = 0; hunt_age = 0; zero_run = 0;
      m_rcnt = 0; m_tcnt = 0; m_lost = 0; m_to = 0;
      rd_hist[0] = 0; rd_hist[1] = 0;
   endtask

   task automatic model_lose();
      m_mode = 1; run_len = 0; hunt_age = 0; m_lost = 1;
      if (m_rcnt < CMAX) m_rcnt++;
   endtask

   task automatic model_edge(input bit en, input bit rd, input bit al, input bit ra);
      bit rd_s;
      rd_s = rd_hist[1];
      rd_hist[1] = rd_hist[0];
      rd_hist[0] = rd;
      m_lost = 0; m_to = 0;
      if (!en || !rd_s) m_mode = 0;
      else if (m_mode == 0) begin
         m_mode = 1; run_len = 0; hunt_age = 0;
      end else if (m_mode == 1) begin
         run_len = (al && !ra) ? run_len + 1 : 0;
         hunt_age++;
         if (run_len == STABLE) begin
            m_mode = 2; zero_run = 0;
         end else if (hunt_age == HT) begin
            m_to = 1; hunt_age = 0;
            if (m_tcnt < CMAX) m_tcnt++;
         end
      end else begin
         if (ra) model_lose();
         else if (!al) begin
            zero_run++;
            if (zero_run == LOSS) model_lose();
         end else zero_run = 0;
      end
   endtask

   task automatic step(input bit en, input bit rd, input bit al, input bit ra);
      enable = en; rx_resetdone = rd; rxbyteisaligned = al; rxbyterealign = ra;
      @(posedge clk);
      model_edge(en, rd, al, ra);
      #1;
   endtask

   task automatic do_reset();
      resetn = 1'b0; enable = 1'b1; rx_resetdone = 1'b1;
      rxbyteisaligned = 1'b0; rxbyterealign = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 resetn = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      tests++;
      if (obs !== 20'h0) begin
         errors++; $display("FAIL reset_outputs: got %h want 00000", obs);
      end
   endtask

   task automatic test_hunt_entry();
      for (int c = 1; c <= 3; c++) begin
         step(1, 1, 0, 0);
         tests++;
         if (rxcommaalignen_out !== (c == 3) || aligned !== 1'b0) begin
            errors++;
            $display("FAIL hunt_entry cycle %0d: en_out=%b aligned=%b want %b 0", c, rxcommaalignen_out, aligned, c == 3);
         end
      end
   endtask

   task automatic test_lock();
      for (int c = 1; c <= 26; c++) begin
         step(1, 1, c != 10, 0);
         tests++;
         if (obs !== expv) begin
            errors++; $display("FAIL lock_model cycle %0d: got %h want %h", c, obs, expv);
         end
         if (c == 25 || c == 26) begin
            tests++;
            if (aligned !== (c == 26) || rxcommaalignen_out !== (c != 26)) begin
               errors++;
               $display("FAIL lock_latency cycle %0d: aligned=%b en_out=%b want %b %b", c, aligned, rxcommaalignen_out, c == 26, c != 26);
            end
         end
      end
   endtask

   task automatic test_loss();
      bit pat[9] = '{0, 0, 0, 1, 0, 0, 0, 0, 1};
      for (int c = 0; c < 9; c++) begin
         step(1, 1, pat[c], 0);
         tests++;
         if (obs !== expv) begin
            errors++; $display("FAIL loss_model step %0d: got %h want %h", c, obs, expv);
         end
      end
      // state after step 7 is what matters; re-check the loss signature from the model history
      tests++;
      if (realign_cnt !== 8'd1 || rxcommaalignen_out !== 1'b1 || aligned !== 1'b0) begin
         errors++; $display("FAIL loss_rehunt: rcnt=%0d en_out=%b aligned=%b want 1 1 0", realign_cnt, rxcommaalignen_out, aligned);
      end
   endtask

   task automatic test_realign();
      repeat (STABLE) step(1, 1, 1, 0);
      tests++;
      if (aligned !== 1'b1) begin
         errors++; $display("FAIL relock: aligned=%b want 1", aligned);
      end
      step(1, 1, 1, 1);
      tests++;
      if (aligned !== 1'b0 || align_lost !== 1'b1 || realign_cnt !== 8'd2 || rxcommaalignen_out !== 1'b1) begin
         errors++;
         $display("FAIL realign: aligned=%b lost=%b rcnt=%0d en_out=%b want 0 1 2 1", aligned, align_lost, realign_cnt, rxcommaalignen_out);
      end
      step(1, 1, 1, 0);
      tests++;
      if (align_lost !== 1'b0) begin
         errors++; $display("FAIL realign_pulse_width: lost=%b want 0", align_lost);
      end
   endtask

   task automatic test_enable_drop();
      repeat (STABLE) step(1, 1, 1, 0);
      step(0, 1, 1, 0);
      tests++;
      if (aligned !== 1'b0 || align_lost !== 1'b0 || rxcommaalignen_out !== 1'b0 || realign_cnt !== 8'd2) begin
         errors++;
         $display("FAIL enable_drop: aligned=%b lost=%b en_out=%b rcnt=%0d want 0 0 0 2", aligned, align_lost, rxcommaalignen_out, realign_cnt);
      end
      step(1, 1, 1, 0);
      tests++;
      if (obs !== expv) begin
         errors++; $display("FAIL enable_resume: got %h want %h", obs, expv);
      end
   endtask

   task automatic test_random();
      bit en, rd, al, ra;
      int bad;
      do_reset();
      en = 1; rd = 1; bad = 0;
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 199) == 0) en = ~en;
         if ($urandom_range(0, 299) == 0) rd = ~rd;
         al = ($urandom_range(0, 99) < 96);
         ra = ($urandom_range(0, 99) == 0);
         step(en, rd, al, ra);
         tests++;
         if (obs !== expv) begin
            errors++;
            if (bad < 10) $display("FAIL random cycle %0d: got %h want %h", c, obs, expv);
            bad++;
         end
      end
   endtask

   task automatic test_timeout();
      int last, pulses, bad;
      last = -1; pulses = 0; bad = 0;
      for (int c = 0; c < 2500; c++) begin
         step(1, 1, 0, 0);
         tests++;
         if (obs !== expv) begin
            errors++;
            if (bad < 10) $display("FAIL timeout_model cycle %0d: got %h want %h", c, obs, expv);
            bad++;
         end
         if (hunt_timeout === 1'b1) begin
            if (last >= 0) begin
               tests++;
               if (c - last !== HT) begin
                  errors++; $display("FAIL timeout_period: got %0d want %0d", c - last, HT);
               end
            end
            last = c; pulses++;
         end
      end
      tests++;
      if (pulses < 300 || timeout_cnt !== 8'd255) begin
         errors++; $display("FAIL timeout_saturate: pulses=%0d cnt=%0d want >=300 255", pulses, timeout_cnt);
      end
   endtask

   task automatic test_async_reset();
      tests++;
      if (rxcommaalignen_out !== 1'b1) begin
         errors++; $display("FAIL pre_async_hunt: en_out=%b want 1", rxcommaalignen_out);
      end
      #2 resetn = 1'b0;
      #1;
      tests++;
      if (obs !== 20'h0) begin
         errors++; $display("FAIL async_reset: got %h want 00000", obs);
      end
      model_reset();
      @(posedge clk);
      #1 resetn = 1'b1;
      step(1, 1, 0, 0);
      tests++;
      if (obs !== expv) begin
         errors++; $display("FAIL post_async_reset: got %h want %h", obs, expv);
      end
   endtask

   initial begin
      test_reset();
      test_hunt_entry();
      test_lock();
      test_loss();
      test_realign();
      test_enable_drop();
      test_random();
      test_timeout();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end
endmodule
